mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: slave-wait cycles before a transaction is aborted; legal range 1..65535.
REQ-002 SHALL have ports clk, input, 1: sole clock, all state on rising edge.
REQ-003 SHALL have ports reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have ports m0_mem_valid/m0_mem_instr, input, 1 each: master 0 (core) request and fetch flag.
REQ-005 SHALL have ports m0_mem_addr/m0_mem_wdata, input, 32 each; m0_mem_wstrb, input, 4.
REQ-006 SHALL have ports m0_mem_ready, output, 1, and m0_mem_rdata, output, 32: master 0 completion and read data.
REQ-007 SHALL have ports m1_* identical to REQ-004..006 for master 1 (debug/DMA).
REQ-008 SHALL have ports mem_valid/mem_instr, output, 1; mem_addr/mem_wdata, output, 32; mem_wstrb, output, 4: shared slave request.
REQ-009 SHALL have ports mem_ready, input, 1, and mem_rdata, input, 32: slave response.
REQ-010 SHALL have ports bus_error, output, 1: sticky timeout flag; grant_owner, output, 1: master of the last grant.

Function
REQ-011 SHALL follow the picorv32 protocol on all three ports: request held until ready; wstrb==0 means read.
REQ-012 SHALL implement states IDLE, BUSY, RESP; owner register selects the master.
REQ-013 IDLE: if any mN_mem_valid is high, SHALL grant, latch that master's instr/addr/wdata/wstrb into the mem_* registers, set mem_valid=1, clear the wait counter, and move to BUSY on the next edge.
REQ-014 Simultaneous requests SHALL resolve round-robin: grant the master that is not grant_owner; a single requester SHALL always win.
REQ-015 BUSY with mem_ready=1 SHALL, at that edge, clear mem_valid, capture mem_rdata into the owner's mN_mem_rdata, set the owner's mN_mem_ready=1, and enter RESP.
REQ-016 RESP SHALL last exactly one cycle with the owner's ready high and make no new grant, then return to IDLE; this stops a master's stale valid from being regranted.
REQ-017 Minimum latency SHALL be request-sampled to mN_mem_ready = 2 cycles plus slave latency; zero-wait slave: valid at cycle 0 gives ready at cycle 2.
REQ-018 The non-owner's mN_mem_ready SHALL stay 0, and its mN_mem_rdata SHALL hold its last value.
REQ-019 BUSY SHALL increment a 16-bit wait counter each cycle mem_ready=0; when the counter equals TIMEOUT, SHALL clear mem_valid, return rdata=0 with ready to the owner via RESP, and set bus_error.
REQ-020 bus_error SHALL stay set until reset; further transactions SHALL proceed normally.
REQ-021 mem_addr/mem_wdata/mem_wstrb/mem_instr SHALL be stable while mem_valid=1; master-input changes during BUSY SHALL be ignored.
REQ-022 A master dropping valid mid-transaction (protocol violation) SHALL NOT abort the slave transaction; ready is still pulsed.

Reset
REQ-023 reset=1 at an edge SHALL force IDLE, all outputs 0, grant_owner=1 (so master 0 wins first tie), bus_error=0, counter=0.
REQ-024 Reset mid-BUSY SHALL drop mem_valid on the same edge with no response to either master.

Structure
REQ-025 State encoding (IDLE/BUSY/RESP) and the default TIMEOUT constant SHALL live in shared package mem_pkg.
REQ-026 SHALL be single-level, no sub-modules; expected 150-250 lines of RTL.

Verification
REQ-027 Single read: m0 valid, addr=0x100, wstrb=0; slave ready 1 cycle after valid with 0xDEADBEEF -> m0_mem_ready pulse 1 cycle, m0_mem_rdata=0xDEADBEEF, m1 untouched.
REQ-028 Tie: m0 and m1 both valid from reset -> m0 served first, m1 next, mem_addr sequence m0_addr then m1_addr, grant_owner 0 then 1.
REQ-029 Write: m1 wstrb=0x3, wdata=0x12345678, addr=0x204 -> mem_* carries the same values, stable for 3 slave wait cycles.
REQ-030 Timeout: TIMEOUT=4, slave never ready -> mem_valid drops after 4 wait cycles, m0_mem_ready=1 with rdata=0, bus_error=1 and sticky.
REQ-031 Continuous contention: both held valid over 6 transactions -> strictly alternating grants, no master ready twice in a row.
REQ-032 Reset asserted in BUSY -> next cycle mem_valid=0, no mN_mem_ready, state IDLE.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the two-master memory arbiter: FSM encoding,
// timeout default and the round-robin grant helper.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    localparam int unsigned DEFAULT_TIMEOUT = 32'd255;
    localparam int unsigned WAIT_W          = 32'd16;

    // Returns 1 when master 1 should be granted; a tie goes to the master that did not win last time.
    function automatic logic pick_m1(input logic v0, input logic v1, input logic last_owner);
        logic sel;
        if (v0 && v1) begin
            sel = ~last_owner;
        end else if (v1) begin
            sel = 1'b1;
        end else begin
            sel = 1'b0;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter onto one picorv32-style memory port,
// with a slave-wait timeout that completes the access with zero data and a sticky error.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_mem_valid,
    input  logic        m0_mem_instr,
    input  logic [31:0] m0_mem_addr,
    input  logic [31:0] m0_mem_wdata,
    input  logic [3:0]  m0_mem_wstrb,
    output logic        m0_mem_ready,
    output logic [31:0] m0_mem_rdata,

    input  logic        m1_mem_valid,
    input  logic        m1_mem_instr,
    input  logic [31:0] m1_mem_addr,
    input  logic [31:0] m1_mem_wdata,
    input  logic [3:0]  m1_mem_wstrb,
    output logic        m1_mem_ready,
    output logic [31:0] m1_mem_rdata,

    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,

    output logic        bus_error,
    output logic        grant_owner
);

    // Abort fires on the wait cycle whose increment would reach TIMEOUT.
    localparam logic [WAIT_W-1:0] WAIT_LAST = 16'(TIMEOUT - 32'd1);

    arb_state_e        state_q,     state_d;
    logic              owner_q,     owner_d;
    logic              mem_valid_q, mem_valid_d;
    logic              mem_instr_q, mem_instr_d;
    logic [31:0]       mem_addr_q,  mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic              m0_ready_q,  m0_ready_d;
    logic [31:0]       m0_rdata_q,  m0_rdata_d;
    logic              m1_ready_q,  m1_ready_d;
    logic [31:0]       m1_rdata_q,  m1_rdata_d;
    logic [WAIT_W-1:0] wait_q,      wait_d;
    logic              bus_error_q, bus_error_d;
    logic              grant_m1_s;
    logic              any_req_s;

    assign any_req_s  = m0_mem_valid | m1_mem_valid;
    assign grant_m1_s = pick_m1(m0_mem_valid, m1_mem_valid, owner_q);

    // Next-state and registered-output computation for the arbiter FSM.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_valid_d = mem_valid_q;
        mem_instr_d = mem_instr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        m0_ready_d  = 1'b0;
        m1_ready_d  = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        wait_d      = wait_q;
        bus_error_d = bus_error_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    owner_d     = grant_m1_s;
                    mem_valid_d = 1'b1;
                    mem_instr_d = grant_m1_s ? m1_mem_instr : m0_mem_instr;
                    mem_addr_d  = grant_m1_s ? m1_mem_addr  : m0_mem_addr;
                    mem_wdata_d = grant_m1_s ? m1_mem_wdata : m0_mem_wdata;
                    mem_wstrb_d = grant_m1_s ? m1_mem_wstrb : m0_mem_wstrb;
                    wait_d      = 16'd0;
                    state_d     = ST_BUSY;
                end else begin
                    state_d     = ST_IDLE;
                end
            end

            ST_BUSY: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    state_d     = ST_RESP;
                    if (owner_q) begin
                        m1_ready_d = 1'b1;
                        m1_rdata_d = mem_rdata;
                    end else begin
                        m0_ready_d = 1'b1;
                        m0_rdata_d = mem_rdata;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    mem_valid_d = 1'b0;
                    bus_error_d = 1'b1;
                    wait_d      = wait_q + 16'd1;
                    state_d     = ST_RESP;
                    if (owner_q) begin
                        m1_ready_d = 1'b1;
                        m1_rdata_d = 32'd0;
                    end else begin
                        m0_ready_d = 1'b1;
                        m0_rdata_d = 32'd0;
                    end
                end else begin
                    wait_d      = wait_q + 16'd1;
                end
            end

            // One dead cycle so a master still holding its old valid is not regranted.
            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d     = ST_IDLE;
                mem_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b1;
            mem_valid_q <= 1'b0;
            mem_instr_q <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_wstrb_q <= 4'd0;
            m0_ready_q  <= 1'b0;
            m0_rdata_q  <= 32'd0;
            m1_ready_q  <= 1'b0;
            m1_rdata_q  <= 32'd0;
            wait_q      <= 16'd0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_valid_q <= mem_valid_d;
            mem_instr_q <= mem_instr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            m0_ready_q  <= m0_ready_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_ready_q  <= m1_ready_d;
            m1_rdata_q  <= m1_rdata_d;
            wait_q      <= wait_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign mem_valid    = mem_valid_q;
    assign mem_instr    = mem_instr_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_wstrb    = mem_wstrb_q;
    assign m0_mem_ready = m0_ready_q;
    assign m0_mem_rdata = m0_rdata_q;
    assign m1_mem_ready = m1_ready_q;
    assign m1_mem_rdata = m1_rdata_q;
    assign bus_error    = bus_error_q;
    assign grant_owner  = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected grants and
// responses; independent monitors pop and compare what the DUT presents.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_mem_valid, m0_mem_instr, m0_mem_ready;
    logic [31:0] m0_mem_addr, m0_mem_wdata, m0_mem_rdata;
    logic [3:0]  m0_mem_wstrb;
    logic        m1_mem_valid, m1_mem_instr, m1_mem_ready;
    logic [31:0] m1_mem_addr, m1_mem_wdata, m1_mem_rdata;
    logic [3:0]  m1_mem_wstrb;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        bus_error, grant_owner;

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .m0_mem_valid(m0_mem_valid), .m0_mem_instr(m0_mem_instr),
        .m0_mem_addr(m0_mem_addr), .m0_mem_wdata(m0_mem_wdata), .m0_mem_wstrb(m0_mem_wstrb),
        .m0_mem_ready(m0_mem_ready), .m0_mem_rdata(m0_mem_rdata),
        .m1_mem_valid(m1_mem_valid), .m1_mem_instr(m1_mem_instr),
        .m1_mem_addr(m1_mem_addr), .m1_mem_wdata(m1_mem_wdata), .m1_mem_wstrb(m1_mem_wstrb),
        .m1_mem_ready(m1_mem_ready), .m1_mem_rdata(m1_mem_rdata),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .bus_error(bus_error), .grant_owner(grant_owner)
    );

    typedef struct packed {
        logic        who;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
    } grant_t;

    typedef struct packed {
        logic        who;
        logic [31:0] rdata;
    } resp_t;

    // Slave answers with addr + SLV_K, so 0x100 reads back 0xDEADBEEF.
    localparam logic [31:0] SLV_K = 32'hDEAD_BDEF;

    grant_t grant_q[$];
    resp_t  resp_q[$];
    int     checks = 0;
    int     failures = 0;
    bit     mon_en = 1'b0;
    bit     slave_on = 1'b1;
    int     slave_wait = 0;
    int     scnt = 0;
    int     last_burst_len = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_grant(input logic who, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input logic instr);
        grant_t g;
        g.who = who; g.addr = addr; g.wdata = wdata; g.wstrb = wstrb; g.instr = instr;
        grant_q.push_back(g);
    endtask

    task automatic push_resp(input logic who, input logic [31:0] rdata);
        resp_t r;
        r.who = who; r.rdata = rdata;
        resp_q.push_back(r);
    endtask

    // One picorv32-style request: hold until ready, then drop valid one edge later.
    task automatic do_req(input logic m, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic instr, output int lat);
        if (m == 1'b0) begin
            m0_mem_valid = 1'b1; m0_mem_addr = addr; m0_mem_wdata = wdata;
            m0_mem_wstrb = wstrb; m0_mem_instr = instr;
        end else begin
            m1_mem_valid = 1'b1; m1_mem_addr = addr; m1_mem_wdata = wdata;
            m1_mem_wstrb = wstrb; m1_mem_instr = instr;
        end
        lat = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if ((m == 1'b0 && m0_mem_ready) || (m == 1'b1 && m1_mem_ready)) begin
                lat = i;
                break;
            end
        end
        check("req_completed", 64'(lat >= 0), 64'd1);
        @(posedge clk); #1;
        if (m == 1'b0) m0_mem_valid = 1'b0;
        else           m1_mem_valid = 1'b0;
    endtask

    // Slave model: ready after slave_wait cycles of mem_valid, or never when disabled.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (mem_valid && slave_on) begin
                if (scnt == slave_wait) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_addr + SLV_K;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = 32'hBAD0_BAD0;
                end
                scnt++;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 32'hBAD0_BAD0;
                scnt = 0;
            end
        end
    end

    // Grant monitor: checks each new slave request and its stability while valid.
    initial begin
        grant_t e;
        grant_t cur;
        bit     prev;
        int     blen;
        prev = 1'b0;
        blen = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (mem_valid && !prev) begin
                    cur.who = grant_owner; cur.addr = mem_addr; cur.wdata = mem_wdata;
                    cur.wstrb = mem_wstrb; cur.instr = mem_instr;
                    blen = 1;
                    if (grant_q.size() == 0) begin
                        check("grant_unexpected", 64'(mem_valid), 64'd0);
                    end else begin
                        e = grant_q.pop_front();
                        check("grant_owner", 64'(cur.who), 64'(e.who));
                        check("grant_addr", 64'(cur.addr), 64'(e.addr));
                        check("grant_wdata", 64'(cur.wdata), 64'(e.wdata));
                        check("grant_wstrb_instr", 64'({cur.wstrb, cur.instr}), 64'({e.wstrb, e.instr}));
                    end
                end else if (mem_valid && prev) begin
                    blen++;
                    check("req_stable_addr", 64'(mem_addr), 64'(cur.addr));
                    check("req_stable_rest", 64'({mem_instr, mem_wstrb, mem_wdata}),
                          64'({cur.instr, cur.wstrb, cur.wdata}));
                end else if (!mem_valid && prev) begin
                    last_burst_len = blen;
                end else begin
                    blen = 0;
                end
                prev = mem_valid;
            end
        end
    end

    // Response monitor: every ready pulse must match the next expected response.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && (m0_mem_ready || m1_mem_ready)) begin
                check("resp_single_ready", 64'(m0_mem_ready & m1_mem_ready), 64'd0);
                if (resp_q.size() == 0) begin
                    check("resp_unexpected", 64'({m1_mem_ready, m0_mem_ready}), 64'd0);
                end else begin
                    e = resp_q.pop_front();
                    check("resp_who", 64'(m1_mem_ready), 64'(e.who));
                    check("resp_rdata", 64'(m1_mem_ready ? m1_mem_rdata : m0_mem_rdata), 64'(e.rdata));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int lat_a;
        int lat_b;
        int found;

        reset = 1'b1;
        m0_mem_valid = 1'b0; m0_mem_instr = 1'b0; m0_mem_addr = 32'h0;
        m0_mem_wdata = 32'h0; m0_mem_wstrb = 4'h0;
        m1_mem_valid = 1'b0; m1_mem_instr = 1'b0; m1_mem_addr = 32'h0;
        m1_mem_wdata = 32'h0; m1_mem_wstrb = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_ready", 64'({m0_mem_ready, m1_mem_ready}), 64'd0);
        check("rst_rdata", 64'({m0_mem_rdata, m1_mem_rdata}), 64'd0);
        check("rst_mem_bus", 64'({mem_instr, mem_wstrb, mem_addr}), 64'd0);
        check("rst_grant_owner", 64'(grant_owner), 64'd1);
        check("rst_bus_error", 64'(bus_error), 64'd0);
        @(posedge clk); #1;

        // Tie straight out of reset: m0 first, then m1.
        slave_wait = 0;
        push_grant(1'b0, 32'h200, 32'h0, 4'h0, 1'b0);
        push_grant(1'b1, 32'h400, 32'h0, 4'h0, 1'b0);
        push_resp(1'b0, 32'hDEAD_BFEF);
        push_resp(1'b1, 32'hDEAD_C1EF);
        fork
            do_req(1'b0, 32'h200, 32'h0, 4'h0, 1'b0, lat_a);
            do_req(1'b1, 32'h400, 32'h0, 4'h0, 1'b0, lat_b);
        join
        check("tie_m0_latency", 64'(lat_a), 64'd2);
        check("tie_m1_latency", 64'(lat_b), 64'd5);
        check("tie_owner_after", 64'(grant_owner), 64'd1);

        // Single read, slave one wait cycle.
        slave_wait = 1;
        push_grant(1'b0, 32'h100, 32'h0, 4'h0, 1'b0);
        push_resp(1'b0, 32'hDEAD_BEEF);
        do_req(1'b0, 32'h100, 32'h0, 4'h0, 1'b0, lat_a);
        check("read_latency", 64'(lat_a), 64'd3);
        check("read_m0_rdata_held", 64'(m0_mem_rdata), 64'hDEAD_BEEF);
        check("read_m1_untouched", 64'(m1_mem_rdata), 64'hDEAD_C1EF);

        // Zero-wait slave, instruction fetch: minimum latency.
        slave_wait = 0;
        push_grant(1'b0, 32'h300, 32'h0, 4'h0, 1'b1);
        push_resp(1'b0, 32'hDEAD_C0EF);
        do_req(1'b0, 32'h300, 32'h0, 4'h0, 1'b1, lat_a);
        check("min_latency", 64'(lat_a), 64'd2);

        // Write from m1 with three slave wait cycles.
        slave_wait = 3;
        push_grant(1'b1, 32'h204, 32'h1234_5678, 4'h3, 1'b0);
        push_resp(1'b1, 32'hDEAD_BFF3);
        do_req(1'b1, 32'h204, 32'h1234_5678, 4'h3, 1'b0, lat_a);
        check("write_latency", 64'(lat_a), 64'd5);
        check("write_burst_len", 64'(last_burst_len), 64'd4);

        // m0 drops valid and scribbles its inputs mid-transaction.
        slave_wait = 2;
        push_grant(1'b0, 32'h500, 32'h0, 4'h0, 1'b0);
        push_resp(1'b0, 32'hDEAD_C2EF);
        m0_mem_valid = 1'b1; m0_mem_addr = 32'h500; m0_mem_wdata = 32'h0;
        m0_mem_wstrb = 4'h0; m0_mem_instr = 1'b0;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_valid) begin found = 1; break; end
        end
        check("drop_granted", 64'(found), 64'd1);
        @(posedge clk); #1;
        m0_mem_valid = 1'b0; m0_mem_addr = 32'hFFFF_FFFF;
        m0_mem_wdata = 32'h5555_5555; m0_mem_wstrb = 4'hF;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m0_mem_ready) begin found = 1; break; end
        end
        check("drop_still_ready", 64'(found), 64'd1);
        @(posedge clk); #1;
        check("drop_m1_rdata_held", 64'(m1_mem_rdata), 64'hDEAD_BFF3);

        // Timeout with a dead slave, then a normal access with the flag still set.
        slave_on = 1'b0;
        push_grant(1'b0, 32'h600, 32'h0, 4'h0, 1'b0);
        push_resp(1'b0, 32'h0);
        do_req(1'b0, 32'h600, 32'h0, 4'h0, 1'b0, lat_a);
        check("timeout_latency", 64'(lat_a), 64'd5);
        check("timeout_burst_len", 64'(last_burst_len), 64'd4);
        check("timeout_bus_error", 64'(bus_error), 64'd1);
        slave_on = 1'b1;
        slave_wait = 0;
        push_grant(1'b1, 32'h700, 32'h0, 4'h0, 1'b0);
        push_resp(1'b1, 32'hDEAD_C4EF);
        do_req(1'b1, 32'h700, 32'h0, 4'h0, 1'b0, lat_a);
        check("after_timeout_latency", 64'(lat_a), 64'd2);
        check("bus_error_sticky", 64'(bus_error), 64'd1);

        // Continuous contention over six transactions: strict alternation from m0.
        slave_wait = 1;
        push_grant(1'b0, 32'h800, 32'h0, 4'h0, 1'b0); push_resp(1'b0, 32'hDEAD_C5EF);
        push_grant(1'b1, 32'h900, 32'h0, 4'h0, 1'b0); push_resp(1'b1, 32'hDEAD_C6EF);
        push_grant(1'b0, 32'h810, 32'h0, 4'h0, 1'b0); push_resp(1'b0, 32'hDEAD_C5FF);
        push_grant(1'b1, 32'h910, 32'h0, 4'h0, 1'b0); push_resp(1'b1, 32'hDEAD_C6FF);
        push_grant(1'b0, 32'h820, 32'h0, 4'h0, 1'b0); push_resp(1'b0, 32'hDEAD_C60F);
        push_grant(1'b1, 32'h920, 32'h0, 4'h0, 1'b0); push_resp(1'b1, 32'hDEAD_C70F);
        fork
            begin
                do_req(1'b0, 32'h800, 32'h0, 4'h0, 1'b0, lat_a);
                do_req(1'b0, 32'h810, 32'h0, 4'h0, 1'b0, lat_a);
                do_req(1'b0, 32'h820, 32'h0, 4'h0, 1'b0, lat_a);
            end
            begin
                do_req(1'b1, 32'h900, 32'h0, 4'h0, 1'b0, lat_b);
                do_req(1'b1, 32'h910, 32'h0, 4'h0, 1'b0, lat_b);
                do_req(1'b1, 32'h920, 32'h0, 4'h0, 1'b0, lat_b);
            end
        join

        // Reset while the slave is stalled: no response, back to idle.
        slave_on = 1'b0;
        push_grant(1'b1, 32'hA00, 32'h0, 4'h0, 1'b0);
        m1_mem_valid = 1'b1; m1_mem_addr = 32'hA00; m1_mem_wdata = 32'h0;
        m1_mem_wstrb = 4'h0; m1_mem_instr = 1'b0;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_valid) begin found = 1; break; end
        end
        check("busy_reset_granted", 64'(found), 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        m1_mem_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("busy_reset_mem_valid", 64'(mem_valid), 64'd0);
        check("busy_reset_ready", 64'({m0_mem_ready, m1_mem_ready}), 64'd0);
        check("busy_reset_owner", 64'(grant_owner), 64'd1);
        check("busy_reset_bus_error", 64'(bus_error), 64'd0);
        @(negedge clk);
        check("busy_reset_idle", 64'(mem_valid), 64'd0);
        @(posedge clk); #1;
        slave_on = 1'b1;
        slave_wait = 0;
        push_grant(1'b0, 32'hB00, 32'h0, 4'h0, 1'b0);
        push_resp(1'b0, 32'hDEAD_C8EF);
        do_req(1'b0, 32'hB00, 32'h0, 4'h0, 1'b0, lat_a);
        check("post_reset_latency", 64'(lat_a), 64'd2);

        repeat (3) @(negedge clk);
        check("grant_queue_drained", 64'(grant_q.size()), 64'd0);
        check("resp_queue_drained", 64'(resp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
